// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control FSM: state encoding,
// opcode constants, mux select codes and the opcode decode function.
package mc_ctrl_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RF_WSEL_ALU = 2'd0;
  localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
  localparam logic [1:0] RF_WSEL_EXT = 2'd2;
  localparam logic [1:0] RF_WSEL_RDO = 2'd3;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  // Instruction class decides the state path; CLS_ILL covers unlisted opcodes.
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_LUI, CLS_ILL
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic [1:0] wsel;
    logic [2:0] sext;
    logic       bsel;
    logic [1:0] npc;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d.cls  = CLS_ILL;
    d.wsel = RF_WSEL_ALU;
    d.sext = SEXT_I;
    d.bsel = 1'b0;
    d.npc  = NPC_PC4;
    case (op)
      OP_R:      d.cls = CLS_ALU;
      OP_I_ALU:  begin d.cls = CLS_ALU;    d.bsel = 1'b1; end
      OP_LOAD:   begin d.cls = CLS_LOAD;   d.bsel = 1'b1; d.wsel = RF_WSEL_RDO; end
      OP_STORE:  begin d.cls = CLS_STORE;  d.bsel = 1'b1; d.sext = SEXT_S; end
      OP_BRANCH: begin d.cls = CLS_BRANCH; d.sext = SEXT_B; end
      OP_JAL:    begin d.cls = CLS_JUMP;   d.wsel = RF_WSEL_PC4; d.npc = NPC_JAL; d.sext = SEXT_J; end
      OP_JALR:   begin d.cls = CLS_JUMP;   d.wsel = RF_WSEL_PC4; d.npc = NPC_JALR; end
      OP_LUI:    begin d.cls = CLS_LUI;    d.wsel = RF_WSEL_EXT; d.sext = SEXT_U; end
      default:   d.cls = CLS_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_CTRL_TRAP_EN to trap on unlisted opcodes; otherwise they retire as NOPs.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        irom_ack,
  input  logic        dram_ack,
  input  logic        br_taken,
  output logic        irom_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [2:0]  sext_op,
  output logic        alu_bsel,
  output logic        dram_req,
  output logic        dram_we,
  output logic        instret
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_t r_state;
  state_t w_next;
  dec_t   r_dec;
  dec_t   w_dec;
  dec_t   w_act;
  logic   w_run;
  logic   w_retire;
  logic   w_unused_inst;

  assign w_unused_inst = ^inst[31:7];

  always_comb w_dec = decode(inst[6:0]);

  // In DECODE the controls come straight from the decoder so they are valid
  // one cycle before the latched copy exists.
  always_comb w_act = (r_state == S_DECODE) ? w_dec : r_dec;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (irom_ack) w_next = S_DECODE;
      S_DECODE: begin
        case (w_dec.cls)
          CLS_LUI: w_next = S_WB;
          CLS_ILL: begin
`ifdef MC_CTRL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_EXEC;
`endif
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_dec.cls)
          CLS_LOAD, CLS_STORE: w_next = S_MEM;
          CLS_BRANCH, CLS_ILL: w_next = S_FETCH;
          default:             w_next = S_WB;
        endcase
      end
      S_MEM:    if (dram_ack) w_next = (r_dec.cls == CLS_STORE) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is checked
  // first so it overrides any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_dec   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_dec <= w_dec;
    end
  end

  // NOTE: every strobe is gated by !rst so an in-flight instruction is
  // aborted silently, even in the cycle reset is first seen.
  assign w_run    = !rst;
  assign w_retire = w_run && ((r_state == S_WB) ||
                              (r_state == S_MEM  && r_dec.cls == CLS_STORE && dram_ack) ||
                              (r_state == S_EXEC && (r_dec.cls == CLS_BRANCH || r_dec.cls == CLS_ILL)));

  always_comb begin
    irom_req = w_run && (r_state == S_FETCH);
    ir_we    = irom_req && irom_ack;
    pc_we    = w_retire;
    instret  = w_retire;
    rf_we    = w_run && (r_state == S_WB);
    dram_req = w_run && (r_state == S_MEM);
    dram_we  = dram_req && (r_dec.cls == CLS_STORE);
    npc_op   = 2'd0;
    rf_wsel  = 2'd0;
    sext_op  = 3'd0;
    alu_bsel = 1'b0;
    if (w_run) begin
      npc_op   = w_act.npc;
      rf_wsel  = w_act.wsel;
      sext_op  = w_act.sext;
      alu_bsel = w_act.bsel;
      if (r_state == S_EXEC && r_dec.cls == CLS_BRANCH) npc_op = {1'b0, br_taken};
    end
  end

`ifdef MC_CTRL_TRAP_EN
  assign illegal = w_run && (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver pushes the expected retirement of
// each instruction, the monitor pops and compares on every pc_we/instret.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        irom_ack, dram_ack, br_taken;
  logic        irom_req, ir_we, pc_we, rf_we, alu_bsel, dram_req, dram_we, instret;
  logic [1:0]  npc_op, rf_wsel;
  logic [2:0]  sext_op;
`ifdef MC_CTRL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .irom_ack(irom_ack), .dram_ack(dram_ack),
    .br_taken(br_taken), .irom_req(irom_req), .ir_we(ir_we), .pc_we(pc_we),
    .npc_op(npc_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .sext_op(sext_op),
    .alu_bsel(alu_bsel), .dram_req(dram_req), .dram_we(dram_we), .instret(instret)
`ifdef MC_CTRL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  // -1 in a field means "not constrained for this instruction".
  typedef struct {
    int npc; int rfwe; int wsel; int sext; int bsel; int lat; int dram; int dwe;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   g_dwait = 0;
  bit   g_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int npc, rfwe, wsel, sext, bsel, lat, dram, dwe);
    exp_t e;
    e.npc = npc; e.rfwe = rfwe; e.wsel = wsel; e.sext = sext;
    e.bsel = bsel; e.lat = lat; e.dram = dram; e.dwe = dwe;
    return e;
  endfunction

  // Data memory responder: acks after g_dwait wait cycles, or at once when forced.
  int wcnt = 0;
  initial begin
    dram_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (g_force) dram_ack = 1'b1;
      else if (dram_req) begin dram_ack = (wcnt == g_dwait); wcnt++; end
      else begin dram_ack = 1'b0; wcnt = 0; end
    end
  end

  // Monitor: tracks one instruction from ir_we to its retirement.
  int   cyc = 0, t_start = 0, n_dram = 0, n_dwe = 0, n_rfwe = 0, d_sext = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (ir_we) begin t_start = cyc; n_dram = 0; n_dwe = 0; n_rfwe = 0; end
      if (cyc == t_start + 1) d_sext = int'(sext_op);
      if (dram_req) n_dram++;
      if (dram_we)  n_dwe++;
      if (rf_we)    n_rfwe++;
      if (rf_we && !pc_we) check("rf_we_without_retire", rf_we, 0);
      if (pc_we || instret) begin
        check("pc_we_instret_pair", {pc_we, instret}, 2'b11);
        if (sb_q.size() == 0) check("unexpected_retire", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("npc_op", npc_op, e.npc);
          check("latency", cyc - t_start + 1, e.lat);
          check("rf_we_count", n_rfwe, e.rfwe);
          check("dram_req_cycles", n_dram, e.dram);
          check("dram_we_cycles", n_dwe, e.dwe);
          if (e.wsel >= 0) check("rf_wsel", rf_wsel, e.wsel);
          if (e.bsel >= 0) check("alu_bsel", alu_bsel, e.bsel);
          if (e.sext >= 0) begin
            check("sext_op_retire", sext_op, e.sext);
            check("sext_op_decode", d_sext, e.sext);
          end
        end
      end
    end
  end

  // Issue one instruction with zero-wait fetch; returns when FETCH is re-entered.
  task automatic issue(input logic [31:0] i, input logic br, input int dwait, input exp_t x);
    bit done;
    sb_q.push_back(x);
    inst = i; br_taken = br; g_dwait = dwait; irom_ack = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      done = irom_req;
    end
    irom_ack = 1'b0;
    check("instr_completes", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inst = 32'h0; irom_ack = 1'b1; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {irom_req, ir_we, pc_we, rf_we, dram_req, dram_we, instret,
                            npc_op, rf_wsel, sext_op, alu_bsel}, 15'd0);
    @(posedge clk); #1; rst = 1'b0; irom_ack = 1'b0;
    @(negedge clk);
    check("irom_req_after_reset", irom_req, 1);
    @(posedge clk); #1;

    //              npc rfwe wsel sext bsel lat dram dwe
    issue(32'h00208033, 0, 0, mk(0, 1, 0, -1, 0, 4, 0, 0));   // ADD
    issue(32'h00100093, 0, 0, mk(0, 1, 0,  0, 1, 4, 0, 0));   // ADDI
    issue(32'h0000A083, 0, 3, mk(0, 1, 3,  0, 1, 8, 4, 0));   // LW, 3 wait states
    issue(32'h0000A083, 0, 0, mk(0, 1, 3,  0, 1, 5, 1, 0));   // LW, zero wait
    issue(32'h0020A023, 0, 0, mk(0, 0, -1, 1, 1, 4, 1, 1));   // SW, zero wait
    issue(32'h0020A023, 0, 2, mk(0, 0, -1, 1, 1, 6, 3, 3));   // SW, 2 wait states
    issue(32'h00208463, 1, 0, mk(1, 0, -1, 2, -1, 3, 0, 0));  // BEQ taken
    issue(32'h00208463, 0, 0, mk(0, 0, -1, 2, -1, 3, 0, 0));  // BEQ not taken
    issue(32'h008000EF, 0, 0, mk(2, 1, 1,  4, -1, 4, 0, 0));  // JAL
    issue(32'h000080E7, 0, 0, mk(3, 1, 1,  0, -1, 4, 0, 0));  // JALR
    issue(32'h000120B7, 0, 0, mk(0, 1, 2,  3, -1, 3, 0, 0));  // LUI

    // Reset in MEM together with dram_ack: nothing may retire.
    inst = 32'h0000A083; g_dwait = 20; irom_ack = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      irom_ack = 1'b0;
      if (dram_req) break;
    end
    check("abort_reached_mem", dram_req, 1);
    rst = 1'b1; g_force = 1'b1;
    @(negedge clk);
    check("abort_dram_ack_seen", dram_ack, 1);
    check("abort_no_strobes", {pc_we, rf_we, instret, dram_req, dram_we}, 5'd0);
    @(posedge clk); #1; rst = 1'b0; g_force = 1'b0;
    @(negedge clk);
    check("abort_fetch_after_rst", {irom_req, pc_we, rf_we}, 3'b100);
    @(posedge clk); #1;
    issue(32'h00208033, 0, 0, mk(0, 1, 0, -1, 0, 4, 0, 0));   // ADD after abort

`ifdef MC_CTRL_TRAP_EN
    inst = 32'h0000007F; irom_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("trap_illegal", illegal, 1);
      check("trap_quiet", {irom_req, ir_we, pc_we, instret, rf_we, dram_req}, 6'd0);
    end
    @(posedge clk); #1; rst = 1'b1; irom_ack = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("trap_cleared_by_rst", {illegal, irom_req}, 2'b01);
    @(posedge clk); #1;
`else
    issue(32'h0000007F, 0, 0, mk(0, 0, -1, -1, -1, 3, 0, 0)); // unlisted opcode as NOP
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
